rst_ctrl: RTL and testbench
===========================

// Module: rst_ctrl
// PURPOSE
//  Reset source controller that drives the asynchronous reset input of the reset synchronizer.
//  - Merges four reset sources: power-on (rst_n), a debounced board button, PLL lock loss,
//    and software/watchdog requests.
//  - Stretches the merged reset to a guaranteed minimum width.
//  - Records the cause of the most recent reset for the system controller to read.
// PARAMETERS
//  DEBOUNCE_CYCLES  20000  consecutive stable clk cycles required to change the debounced button state
//  STRETCH_CYCLES   64     clk cycles arst_o stays high after every source has gone inactive (>=1)
// PORTS
//  clk          in   1  free-running oscillator clock (not PLL-derived)
//  rst_n        in   1  power-on reset; asynchronous, active-low
//  btn_n_i      in   1  board reset button; asynchronous, active-low, bouncy
//  pll_lock_i   in   1  PLL lock indication; asynchronous
//  sw_rst_i     in   1  software reset request; single-cycle pulse, clk domain
//  wdt_rst_i    in   1  watchdog reset request; single-cycle pulse, clk domain
//  arst_o       out  1  merged reset to the synchronizer; active-high, registered
//  rst_cause_o  out  4  sticky cause {wdt, sw, pll, btn}; 4'b0000 = power-on
// BEHAVIOUR
//  Reset (rst_n low)
//  - arst_o=1, rst_cause_o=0, FSM=S_ASSERT.
//  - Button synchronizer resets to 2'b11; lock synchronizer resets to 2'b00.
//  - Debounced button resets to "released"; debounce counter resets to 0.
//  Synchronization
//  - btn_n_i and pll_lock_i each pass through a 2-flop synchronizer.
//  - Downstream logic sees an input change on the 2nd rising edge after it occurs.
//  Debounce
//  - Counter increments while synced button differs from the debounced state; clears when it matches.
//  - When the counter reaches DEBOUNCE_CYCLES-1 with a difference present, the debounced state flips
//    and the counter clears.
//  - Applies to both press and release.
//  src_active = btn_pressed | ~lock_s | sw_rst_i | wdt_rst_i
//  FSM (arst_o is a registered decode: 1 in S_ASSERT and S_STRETCH, 0 in S_RUN)
//  - S_ASSERT:  if !src_active -> S_STRETCH, load cnt=STRETCH_CYCLES-1.
//  - S_STRETCH: if src_active -> S_ASSERT; else if cnt==0 -> S_RUN; else cnt--.
//  - S_RUN:     if src_active -> S_ASSERT; arst_o rises on that same edge
//               (1-cycle latency from a sw/wdt pulse).
//  Cause capture (rst_cause_o)
//  - On the S_RUN->S_ASSERT edge: rst_cause_o <= {wdt,sw,~lock_s,btn_pressed} sampled that cycle
//    (previous cause cleared).
//  - While in S_ASSERT/S_STRETCH: newly active sources are OR-ed in.
//  - Held unchanged in S_RUN.
//  - A reassertion of rst_n is the only event that clears it to 0.
//  Timing
//  - With lock high and button released, arst_o falls exactly STRETCH_CYCLES+3 rising edges after
//    rst_n deasserts.
//  Boundary conditions
//  - Simultaneous sources: all corresponding cause bits are set.
//  - A sw/wdt pulse during S_STRETCH restarts the stretch from S_ASSERT.
//  - Lock loss at any point holds arst_o high indefinitely until lock returns, then a full stretch
//    follows.
//  - rst_n asserted mid-operation forces the reset values immediately (asynchronous).
// TESTING (bench params DEBOUNCE_CYCLES=8, STRETCH_CYCLES=16)
//  1. Power-on: lock=1, btn=1, release rst_n -> arst_o=1 for 19 edges, 0 from edge 19; rst_cause_o=0.
//  2. In S_RUN, 1-cycle sw_rst_i -> arst_o=1 on next edge; high 17 cycles total; rst_cause_o=4'b0100.
//  3. Button bounce of 3-cycle low glitches -> arst_o stays 0; held low 8+ cycles -> arst_o rises
//     (2+8 cycles after the press); release -> debounce, 16-cycle stretch; rst_cause_o=4'b0001.
//  4. Drop pll_lock_i for 40 cycles in S_RUN -> arst_o high 3 edges later, stays high through the
//     lock gap plus 16 stretch cycles; rst_cause_o=4'b0010.
//  5. wdt_rst_i pulse while in S_STRETCH after a sw reset -> stretch restarts; rst_cause_o=4'b1100.
//  6. Assert rst_n mid-S_STRETCH -> arst_o=1 and rst_cause_o=0 immediately, without waiting for
//     a clk edge.

Source files
------------

// File: rtl/rst_ctrl.sv
// ---------------------------------------------------------------------------
// rst_ctrl
//   Reset source controller feeding the asynchronous input of the reset
//   synchronizer. Merges power-on, a debounced board button, PLL lock loss
//   and software/watchdog requests, stretches the merged reset to a minimum
//   width, and records the cause of the most recent reset.
//
// Ports
//   clk          in   free-running oscillator clock (not PLL-derived)
//   rst_n        in   power-on reset, asynchronous, active-low
//   btn_n_i      in   board reset button, asynchronous, active-low, bouncy
//   pll_lock_i   in   PLL lock indication, asynchronous
//   sw_rst_i     in   software reset request, single-cycle pulse (clk domain)
//   wdt_rst_i    in   watchdog reset request, single-cycle pulse (clk domain)
//   arst_o       out  merged reset, active-high, registered
//   rst_cause_o  out  sticky cause {wdt, sw, pll, btn}; 4'b0000 = power-on
//
// Handshakes: none. sw_rst_i / wdt_rst_i are fire-and-forget pulses that are
// sampled on every rising clk edge; there is no ready/acknowledge path.
// ---------------------------------------------------------------------------
module rst_ctrl #(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int STRETCH_CYCLES  = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_n_i,
  input  logic       pll_lock_i,
  input  logic       sw_rst_i,
  input  logic       wdt_rst_i,
  output logic       arst_o,
  output logic [3:0] rst_cause_o
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam int SW = (STRETCH_CYCLES > 1) ? $clog2(STRETCH_CYCLES + 1) : 1;

  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0] STR_RELOAD = SW'(STRETCH_CYCLES - 1);

  typedef enum logic [1:0] {
    S_ASSERT  = 2'd0,
    S_STRETCH = 2'd1,
    S_RUN     = 2'd2
  } state_t;

  // FSM state is kept as a named signal so checkers can bind to it directly.
  state_t state, state_nxt;

  // -------------------------------------------------------------------------
  // Input synchronizers
  // -------------------------------------------------------------------------
  logic [1:0] btn_sync;
  logic [1:0] lock_sync;
  logic       btn_s;
  logic       lock_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_sync  <= 2'b11;
      lock_sync <= 2'b00;
    end else begin
      btn_sync  <= {btn_sync[0], btn_n_i};
      lock_sync <= {lock_sync[0], pll_lock_i};
    end
  end

  assign btn_s  = btn_sync[1];
  assign lock_s = lock_sync[1];

  // -------------------------------------------------------------------------
  // Button debounce: btn_db is the accepted (active-low) button level.
  // The counter only runs while the synced level disagrees with btn_db.
  // -------------------------------------------------------------------------
  logic          btn_db;
  logic [DW-1:0] db_cnt;
  logic          btn_pressed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_db <= 1'b1;
      db_cnt <= '0;
    end else if (btn_s != btn_db) begin
      if (db_cnt == DB_LAST) begin
        btn_db <= btn_s;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end else begin
      db_cnt <= '0;
    end
  end

  assign btn_pressed = ~btn_db;

  // -------------------------------------------------------------------------
  // Source vector, ordered like rst_cause_o: {wdt, sw, pll_loss, btn}
  // -------------------------------------------------------------------------
  logic [3:0] src_vec;
  logic [3:0] src_q;
  logic [3:0] src_new;
  logic       src_active;

  assign src_vec    = {wdt_rst_i, sw_rst_i, ~lock_s, btn_pressed};
  assign src_active = |src_vec;

  // Previous-cycle sources. The reset value matches the reset state of the
  // synchronizers (lock_s low) so the power-on lock ramp is not mistaken for
  // a fresh lock-loss event and rst_cause_o stays 0 after power-on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) src_q <= 4'b0010;
    else        src_q <= src_vec;
  end

  assign src_new = src_vec & ~src_q;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  logic [SW-1:0] str_cnt, str_cnt_nxt;
  logic          arst_nxt;
  logic [3:0]    cause_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_ASSERT;
      str_cnt     <= '0;
      arst_o      <= 1'b1;
      rst_cause_o <= 4'b0000;
    end else begin
      state       <= state_nxt;
      str_cnt     <= str_cnt_nxt;
      arst_o      <= arst_nxt;
      rst_cause_o <= cause_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt   = state;
    str_cnt_nxt = str_cnt;
    case (state)
      S_ASSERT: begin
        if (!src_active) begin
          state_nxt   = S_STRETCH;
          str_cnt_nxt = STR_RELOAD;
        end
      end
      S_STRETCH: begin
        if (src_active)           state_nxt   = S_ASSERT;
        else if (str_cnt == '0)   state_nxt   = S_RUN;
        else                      str_cnt_nxt = str_cnt - 1'b1;
      end
      S_RUN: begin
        if (src_active) state_nxt = S_ASSERT;
      end
      default: begin
        state_nxt = S_ASSERT;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: output logic (registered in the state register process)
  // arst_o decodes the next state so it rises on the same edge that leaves
  // S_RUN, giving one cycle of latency from a sw/wdt pulse.
  // -------------------------------------------------------------------------
  always_comb begin
    arst_nxt  = (state_nxt != S_RUN);
    cause_nxt = rst_cause_o;
    case (state)
      S_RUN: begin
        // New reset episode: previous cause is replaced.
        if (src_active) cause_nxt = src_vec;
      end
      S_ASSERT, S_STRETCH: begin
        cause_nxt = rst_cause_o | src_new;
      end
      default: begin
        cause_nxt = rst_cause_o;
      end
    endcase
  end

endmodule

// File: tb/tb_rst_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rst_ctrl
//   Self-checking bench for rst_ctrl with DEBOUNCE_CYCLES=8, STRETCH_CYCLES=16.
//   Inputs are driven 1 time unit after a rising edge; outputs are sampled at
//   the same point (well away from the next edge). Expected results are
//   pushed to exp_q when stimulus is applied and popped when measured.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rst_ctrl;

  localparam int DEB = 8;
  localparam int STR = 16;

  logic       clk;
  logic       rst_n;
  logic       btn_n_i;
  logic       pll_lock_i;
  logic       sw_rst_i;
  logic       wdt_rst_i;
  logic       arst_o;
  logic [3:0] rst_cause_o;

  int n_vec;
  int n_err;
  logic [31:0] exp_q[$];

  rst_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .STRETCH_CYCLES (STR)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_n_i    (btn_n_i),
    .pll_lock_i (pll_lock_i),
    .sw_rst_i   (sw_rst_i),
    .wdt_rst_i  (wdt_rst_i),
    .arst_o     (arst_o),
    .rst_cause_o(rst_cause_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic sb_push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic sb_check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: scoreboard empty, got %0d", tag, obs);
    end else begin
      e = exp_q.pop_front();
      check(tag, obs, e);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_sw();
    sw_rst_i = 1'b1;
    step(1);
    sw_rst_i = 1'b0;
  endtask

  task automatic pulse_wdt();
    wdt_rst_i = 1'b1;
    step(1);
    wdt_rst_i = 1'b0;
  endtask

  // Edges until arst_o reaches level 'lvl' (bounded); returns limit+1 on timeout.
  task automatic edges_until(input logic lvl, input int limit, output int n);
    n = 0;
    while (arst_o !== lvl && n <= limit) begin
      step(1);
      n++;
    end
  endtask

  // Number of sampled cycles arst_o stays high, starting from the current sample.
  task automatic high_len(input int limit, output int n);
    n = 0;
    while (arst_o === 1'b1 && n <= limit) begin
      n++;
      step(1);
    end
  endtask

  int n;
  int hi_cnt;
  int lat;

  initial begin
    n_vec      = 0;
    n_err      = 0;
    rst_n      = 1'b0;
    btn_n_i    = 1'b1;
    pll_lock_i = 1'b1;
    sw_rst_i   = 1'b0;
    wdt_rst_i  = 1'b0;
    step(3);

    // 1. Power-on
    check("rst_arst", arst_o, 1);
    check("rst_cause", rst_cause_o, 0);
    rst_n = 1'b1;
    sb_push(STR + 3);
    edges_until(1'b0, 100, n);
    sb_check("por_fall_edge", n);
    check("por_cause", rst_cause_o, 4'b0000);
    step(5);
    check("por_stays_low", arst_o, 0);

    // 2. Software reset from S_RUN
    sw_rst_i = 1'b1;
    step(1);
    sw_rst_i = 1'b0;
    check("sw_latency", arst_o, 1);
    sb_push(STR + 1);
    high_len(100, n);
    sb_check("sw_high_len", n);
    sb_push(4'b0100);
    sb_check("sw_cause", rst_cause_o);

    // 3. Button: short glitches are rejected, a long press resets
    step(4);
    hi_cnt = 0;
    for (int g = 0; g < 3; g++) begin
      btn_n_i = 1'b0;
      for (int i = 0; i < 3; i++) begin step(1); if (arst_o) hi_cnt++; end
      btn_n_i = 1'b1;
      for (int i = 0; i < 3 + $urandom_range(0, 2); i++) begin step(1); if (arst_o) hi_cnt++; end
    end
    for (int i = 0; i < 12; i++) begin step(1); if (arst_o) hi_cnt++; end
    check("btn_glitch_no_reset", hi_cnt, 0);
    btn_n_i = 1'b0;
    edges_until(1'b1, 60, lat);
    // 2 sync edges + DEB stable samples, plus one edge for the FSM to react
    check("btn_press_latency", (lat >= 2 + DEB && lat <= 3 + DEB), 1);
    step(10);
    check("btn_held_high", arst_o, 1);
    btn_n_i = 1'b1;
    edges_until(1'b0, 100, lat);
    check("btn_release_latency", (lat >= 2 + DEB + STR && lat <= 3 + DEB + STR), 1);
    sb_push(4'b0001);
    sb_check("btn_cause", rst_cause_o);

    // 4. PLL lock loss
    step(5);
    pll_lock_i = 1'b0;
    sb_push(3);
    edges_until(1'b1, 20, n);
    sb_check("pll_rise_edge", n);
    hi_cnt = 0;
    for (int i = n; i < 40; i++) begin step(1); if (arst_o) hi_cnt++; end
    check("pll_gap_high", hi_cnt, 40 - n);
    pll_lock_i = 1'b1;
    sb_push(STR + 3);
    edges_until(1'b0, 100, n);
    sb_check("pll_restore_fall", n);
    sb_push(4'b0010);
    sb_check("pll_cause", rst_cause_o);

    // 5. Watchdog pulse during S_STRETCH restarts the stretch
    step(5);
    pulse_sw();
    step(2 + $urandom_range(2, 8));
    check("stretch_still_high", arst_o, 1);
    wdt_rst_i = 1'b1;
    step(1);
    wdt_rst_i = 1'b0;
    // 1 edge back to S_ASSERT, 1 edge to S_STRETCH, STR edges to S_RUN
    sb_push(STR + 1);
    edges_until(1'b0, 100, n);
    sb_check("wdt_restart_fall", n);
    sb_push(4'b1100);
    sb_check("wdt_sw_cause", rst_cause_o);

    // Simultaneous sw + wdt from S_RUN
    step(3);
    sw_rst_i  = 1'b1;
    wdt_rst_i = 1'b1;
    step(1);
    sw_rst_i  = 1'b0;
    wdt_rst_i = 1'b0;
    check("simul_arst", arst_o, 1);
    check("simul_cause", rst_cause_o, 4'b1100);
    edges_until(1'b0, 100, n);

    // 6. Asynchronous rst_n during S_STRETCH
    step(3);
    pulse_sw();
    step(6);
    check("pre_async_cause", rst_cause_o, 4'b0100);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_arst", arst_o, 1);
    check("async_cause", rst_cause_o, 4'b0000);
    #2;
    rst_n = 1'b1;
    step(1);
    sb_push(STR + 2);
    edges_until(1'b0, 100, n);
    sb_check("post_async_fall", n);

    if (exp_q.size() != 0) check("sb_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
